// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand/product widths and
// the state encoding used by the sequential multiplier.
package calc_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mult_state_e;

endpackage : calc_pkg

// File: rtl/somador_8bits.sv
// Structural 8-bit ripple-carry adder built from a chain of full adders.
// The carry out of the top bit is never formed, so the sum wraps modulo 256.
module somador_8bits
    import calc_pkg::*;
(
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [PROD_W-1:0] sum_o
);

    logic [PROD_W-1:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < PROD_W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s[i];
        if (i < PROD_W - 1) begin : g_carry
            assign carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

endmodule : somador_8bits

// File: rtl/mult_seq_4bits.sv
// Sequential 4x4 unsigned shift-and-add multiplier with START/BUSY/DONE
// handshake; one partial product per clock, all outputs registered.
module mult_seq_4bits
    import calc_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [PROD_W-1:0] P,
    output logic              OVF
);

    mult_state_e       state_q, state_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [OP_W-1:0]   mplr_q,  mplr_d;
    logic [PROD_W-1:0] acc_q,   acc_d;
    logic [1:0]        cnt_q,   cnt_d;
    logic [PROD_W-1:0] p_q,     p_d;
    logic              ovf_q,   ovf_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [PROD_W-1:0] partial_s;
    logic [PROD_W-1:0] sum_s;

    assign partial_s = mplr_q[0] ? mcand_q : 8'h00;

    somador_8bits u_somador (
        .a_i   (acc_q),
        .b_i   (partial_s),
        .sum_o (sum_s)
    );

    // Next-state, datapath and output-register updates
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                    mcand_d = {4'b0000, A};
                    mplr_d  = B;
                    acc_d   = 8'h00;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = sum_s;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                    p_d     = sum_s;
                    ovf_d   = |sum_s[7:4];
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Handshake flags are registered copies of the state being entered
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            mcand_q <= 8'h00;
            mplr_q  <= 4'h0;
            acc_q   <= 8'h00;
            cnt_q   <= 2'd0;
            p_q     <= 8'h00;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign P    = p_q;
    assign OVF  = ovf_q;

endmodule : mult_seq_4bits

// File: tb/tb_mult_seq_4bits.sv
// Directed self-checking bench for mult_seq_4bits: handshake timing, async
// reset, level-sensitive START, and a full sweep against a product model.
module tb_mult_seq_4bits;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] p;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    mult_seq_4bits dut (
        .CLK   (clk),
        .RST   (rst),
        .A     (a),
        .B     (b),
        .START (start),
        .BUSY  (busy),
        .DONE  (done),
        .P     (p),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation with START for a single cycle; checks every cycle
    task automatic run_op(input string tag, input logic [3:0] ai, input logic [3:0] bi,
                          input logic [7:0] ep, input logic eo);
        @(negedge clk);
        a = ai; b = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_busy_run"}, {7'd0, busy}, 8'd1);
            chk({tag, "_done_run"}, {7'd0, done}, 8'd0);
            @(negedge clk);
        end
        chk({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done_pulse"}, {7'd0, done}, 8'd1);
        chk({tag, "_p"}, p, ep);
        chk({tag, "_ovf"}, {7'd0, ovf}, {7'd0, eo});
        @(negedge clk);
        chk({tag, "_done_clear"}, {7'd0, done}, 8'd0);
        chk({tag, "_busy_idle"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        logic [7:0] prod;
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_p", p, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        rst = 1'b0;

        run_op("m15x15", 4'd15, 4'd15, 8'hE1, 1'b1);

        // Reset pulse during the 2nd RUN cycle of 9x9 must clear outputs at once
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("m9x9_busy", {7'd0, busy}, 8'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_p", p, 8'h00);
        chk("arst_ovf", {7'd0, ovf}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("arst_no_done", {7'd0, done}, 8'd0);
        end
        chk("arst_p_hold", p, 8'h00);

        run_op("m4x4", 4'd4, 4'd4, 8'h10, 1'b1);
        run_op("m3x5", 4'd3, 4'd5, 8'h0F, 1'b0);
        run_op("m0x9", 4'd0, 4'd9, 8'h00, 1'b0);

        // START held high: operands changed during RUN, second op auto-accepted
        @(negedge clk);
        a = 4'd2; b = 4'd3; start = 1'b1;
        @(negedge clk);
        a = 4'd7; b = 4'd7;
        chk("hold_busy", {7'd0, busy}, 8'd1);
        repeat (3) @(negedge clk);
        chk("hold_done_early", {7'd0, done}, 8'd0);
        @(negedge clk);
        chk("hold_done1", {7'd0, done}, 8'd1);
        chk("hold_p1", p, 8'h06);
        chk("hold_ovf1", {7'd0, ovf}, 8'd0);
        @(negedge clk);
        chk("hold_idle_done", {7'd0, done}, 8'd0);
        chk("hold_idle_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_auto_busy", {7'd0, busy}, 8'd1);
        chk("hold_p_keep", p, 8'h06);
        repeat (3) @(negedge clk);
        chk("hold_done2_early", {7'd0, done}, 8'd0);
        @(negedge clk);
        chk("hold_done2", {7'd0, done}, 8'd1);
        chk("hold_p2", p, 8'h31);
        chk("hold_ovf2", {7'd0, ovf}, 8'd1);
        @(negedge clk);
        chk("hold_end_done", {7'd0, done}, 8'd0);

        // Exhaustive sweep against the arithmetic model
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                prod = 8'(i * j);
                run_op($sformatf("sw_%0dx%0d", i, j), 4'(i), 4'(j), prod, (prod > 8'd15));
                if (j != 0 && !ovf) begin
                    chk($sformatf("div_q_%0dx%0d", i, j), {4'd0, p[3:0] / 4'(j)}, 8'(i));
                    chk($sformatf("div_r_%0dx%0d", i, j), {4'd0, p[3:0] % 4'(j)}, 8'd0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mult_seq_4bits
